// File: rtl/uart_frame_parser.sv
// Receive-side framing stage: hunts for SOF, then parses length, payload and XOR checksum
// from a first-word-fall-through RX FIFO, streaming payload and closing each frame with done/err.
module uart_frame_parser #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         LEN_W   = 8,
    parameter int         TIMEOUT = 65535,
    parameter int         TO_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [7:0]       r_data,
    output logic             rd_uart,
    output logic [7:0]       pl_data,
    output logic             pl_valid,
    output logic             pl_last,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [7:0]       err_cnt,
    output logic             busy
);

    // state     | meaning
    // S_IDLE    | hunting for SOF, other bytes dropped
    // S_LEN     | waiting for the length byte
    // S_PAYLOAD | streaming payload bytes, counting down
    // S_CSUM    | waiting for the checksum byte
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TO   = 2'd3;

    state_t            state, state_n;
    logic [LEN_W-1:0]  cnt, cnt_n;
    logic [7:0]        csum, csum_n;
    logic [TO_W-1:0]   to_cnt, to_n;
    logic [7:0]        pl_data_n;
    logic              pl_valid_n, pl_last_n, done_n, err_n;
    logic [1:0]        err_code_n;
    logic [7:0]        err_cnt_n;
    logic              pop;
    logic              raise;
    logic [1:0]        raise_code;

    assign rd_uart = ~rx_empty;
    assign pop     = ~rx_empty;
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        csum_n     = csum;
        to_n       = to_cnt;
        pl_data_n  = pl_data;
        pl_valid_n = 1'b0;
        pl_last_n  = 1'b0;
        done_n     = 1'b0;
        raise      = 1'b0;
        raise_code = 2'd0;

        case (state)
            S_IDLE: begin
                to_n = '0;
                if (pop && r_data == SOF)
                    state_n = S_LEN;
            end
            S_LEN: begin
                if (pop) begin
                    if (r_data == 8'd0 || r_data > 8'(MAX_LEN)) begin
                        raise      = 1'b1;
                        raise_code = ERR_LEN;
                        state_n    = S_IDLE;
                    end else begin
                        cnt_n   = LEN_W'(r_data);
                        csum_n  = r_data;
                        state_n = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pop) begin
                    csum_n     = csum ^ r_data;
                    cnt_n      = cnt - LEN_W'(1);
                    pl_data_n  = r_data;
                    pl_valid_n = 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        pl_last_n = 1'b1;
                        state_n   = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (pop) begin
                    if (r_data == csum) begin
                        done_n = 1'b1;
                    end else begin
                        raise      = 1'b1;
                        raise_code = ERR_CSUM;
                    end
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A pop always clears the idle counter, so timeout is only judged on empty cycles.
        if (state != S_IDLE) begin
            if (pop) begin
                to_n = '0;
            end else if (to_cnt == TO_W'(TIMEOUT)) begin
                raise      = 1'b1;
                raise_code = ERR_TO;
                state_n    = S_IDLE;
                to_n       = '0;
            end else begin
                to_n = to_cnt + TO_W'(1);
            end
        end

        err_n      = raise;
        err_code_n = raise ? raise_code : err_code;
        err_cnt_n  = (raise && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            csum       <= '0;
            to_cnt     <= '0;
            pl_data    <= '0;
            pl_valid   <= 1'b0;
            pl_last    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            csum       <= csum_n;
            to_cnt     <= to_n;
            pl_data    <= pl_data_n;
            pl_valid   <= pl_valid_n;
            pl_last    <= pl_last_n;
            frame_done <= done_n;
            frame_err  <= err_n;
            err_code   <= err_code_n;
            err_cnt    <= err_cnt_n;
        end
    end

endmodule
